// File: rtl/boton_peaton_if.sv
// Pedestrian button bus: raw button and semaforo lamps in, walk request and status out.
interface boton_peaton_if;
  logic       boton_raw;
  logic       rojo;
  logic       amarillo;
  logic       verde;
  logic       blanco;
  logic       pulsador;
  logic       espera;
  logic [7:0] servicios;
  logic       conflicto;

  modport master (
    output boton_raw, rojo, amarillo, verde, blanco,
    input  pulsador, espera, servicios, conflicto
  );

  modport slave (
    input  boton_raw, rojo, amarillo, verde, blanco,
    output pulsador, espera, servicios, conflicto
  );
endinterface

// File: rtl/boton_peaton.sv
// Pedestrian push-button front end: synchronizer, debouncer, request FSM and lamp-conflict monitor.
// Optional post-walk lockout is built only when BOTON_PEATON_LOCKOUT_EN is defined.
module boton_peaton #(
  parameter int DEB_CYCLES  = 4,
  parameter int LOCK_CYCLES = 16
) (
  input logic          clk,
  input logic          rst,
  boton_peaton_if.slave bus
);

  generate
    if (DEB_CYCLES < 2 || DEB_CYCLES > 255) begin : g_bad_deb
      $error("DEB_CYCLES must be in 2..255");
    end
    if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_bad_lock
      $error("LOCK_CYCLES must be in 1..65535");
    end
  endgenerate

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    WALK = 2'd2
`ifdef BOTON_PEATON_LOCKOUT_EN
    ,
    LOCK = 2'd3
`endif
  } state_t;

  logic [1:0] sync_reg;
  logic       sync_level;
  logic       deb_reg;
  logic [7:0] deb_cnt_reg;
  logic       press_reg;

  state_t     state_reg;
  state_t     state_next;
  logic       pulsador_reg;
  logic       pulsador_next;
  logic       espera_reg;
  logic       espera_next;
  logic [7:0] servicios_reg;
  logic [7:0] servicios_next;
  logic       conflicto_reg;
  logic       conflicto_next;
  logic       lamp_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], bus.boton_raw};
    end
  end

  assign sync_level = sync_reg[1];

  // Level only flips after DEB_CYCLES uninterrupted disagreeing samples; press fires on the rising flip.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_reg     <= 1'b0;
      deb_cnt_reg <= 8'd0;
      press_reg   <= 1'b0;
    end else begin
      press_reg <= 1'b0;
      if (sync_level == deb_reg) begin
        deb_cnt_reg <= 8'd0;
      end else if (deb_cnt_reg == DEB_LAST) begin
        deb_reg     <= sync_level;
        deb_cnt_reg <= 8'd0;
        press_reg   <= sync_level;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + 8'd1;
      end
    end
  end

`ifdef BOTON_PEATON_LOCKOUT_EN
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);
  logic [15:0] lock_cnt_reg;
  logic [15:0] lock_cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt_reg <= 16'd0;
    end else begin
      lock_cnt_reg <= lock_cnt_next;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      pulsador_reg  <= 1'b0;
      espera_reg    <= 1'b0;
      servicios_reg <= 8'd0;
      conflicto_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pulsador_reg  <= pulsador_next;
      espera_reg    <= espera_next;
      servicios_reg <= servicios_next;
      conflicto_reg <= conflicto_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    servicios_next = servicios_reg;
`ifdef BOTON_PEATON_LOCKOUT_EN
    lock_cnt_next  = lock_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        // A walk phase already in progress swallows a coincident press.
        if (bus.blanco) begin
          state_next = WALK;
        end else if (press_reg) begin
          state_next = PEND;
        end
      end
      PEND: begin
        if (bus.blanco) begin
          state_next = WALK;
          if (servicios_reg != 8'hFF) begin
            servicios_next = servicios_reg + 8'd1;
          end
        end
      end
      WALK: begin
        if (!bus.blanco) begin
`ifdef BOTON_PEATON_LOCKOUT_EN
          state_next    = LOCK;
          lock_cnt_next = 16'd0;
`else
          state_next = IDLE;
`endif
        end
      end
`ifdef BOTON_PEATON_LOCKOUT_EN
      LOCK: begin
        if (lock_cnt_reg == LOCK_LAST) begin
          state_next = IDLE;
        end else begin
          lock_cnt_next = lock_cnt_reg + 16'd1;
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase

    pulsador_next = (state_next == PEND);
    espera_next   = (state_next == PEND);
  end

  // Walk lamp with a vehicle-go lamp, or all vehicle lamps dark, is latched until reset.
  always_comb begin
    lamp_bad = (bus.blanco && (bus.verde || bus.amarillo)) ||
               (!bus.rojo && !bus.amarillo && !bus.verde);
    conflicto_next = conflicto_reg | lamp_bad;
  end

  assign bus.pulsador  = pulsador_reg;
  assign bus.espera    = espera_reg;
  assign bus.servicios = servicios_reg;
  assign bus.conflicto = conflicto_reg;

endmodule

// File: tb/tb_boton_peaton.sv
// Directed self-checking bench for boton_peaton with DEB_CYCLES=4, LOCK_CYCLES=16.
module tb_boton_peaton;
  localparam int DEB  = 4;
  localparam int LOCK = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  boton_peaton_if bus ();

  boton_peaton #(
    .DEB_CYCLES (DEB),
    .LOCK_CYCLES(LOCK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Press from IDLE: request must appear on exactly the 7th edge, then the button is released.
  task automatic press_check(input string tag);
    bus.boton_raw = 1'b1;
    repeat (DEB + 2) tick();
    check({tag, "_pre"}, {31'd0, bus.pulsador}, 32'd0);
    tick();
    check({tag, "_puls"}, {31'd0, bus.pulsador}, 32'd1);
    tick();
    bus.boton_raw = 1'b0;
    repeat (8) tick();
  endtask

  task automatic serve(input string tag, input int exp_serv);
    bus.blanco = 1'b1;
    tick();
    check({tag, "_serv"}, {24'd0, bus.servicios}, exp_serv);
    check({tag, "_drop"}, {31'd0, bus.pulsador}, 32'd0);
    tick();
    bus.blanco = 1'b0;
    tick();
`ifdef BOTON_PEATON_LOCKOUT_EN
    repeat (LOCK + 1) tick();
`endif
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    bus.boton_raw = 1'b0;
    bus.rojo      = 1'b1;
    bus.amarillo  = 1'b0;
    bus.verde     = 1'b0;
    bus.blanco    = 1'b0;

    #2 rst = 1'b1;
    #1;
    $display("reset: checking outputs held low");
    check("rst_puls", {31'd0, bus.pulsador}, 32'd0);
    check("rst_esp", {31'd0, bus.espera}, 32'd0);
    check("rst_serv", {24'd0, bus.servicios}, 32'd0);
    check("rst_conf", {31'd0, bus.conflicto}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();

    $display("bounce: toggling every 2 cycles for 20 cycles");
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) bus.boton_raw = ~bus.boton_raw;
      tick();
      check("bounce_puls", {31'd0, bus.pulsador}, 32'd0);
    end
    bus.boton_raw = 1'b0;
    repeat (10) tick();
    check("bounce_puls_end", {31'd0, bus.pulsador}, 32'd0);
    check("bounce_serv", {24'd0, bus.servicios}, 32'd0);

    $display("clean press: held 20 cycles");
    bus.boton_raw = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      check("clean_puls", {31'd0, bus.pulsador}, (n >= DEB + 3) ? 32'd1 : 32'd0);
      check("clean_esp", {31'd0, bus.espera}, (n >= DEB + 3) ? 32'd1 : 32'd0);
    end
    bus.boton_raw = 1'b0;
    repeat (8) tick();
    check("release_no_event", {31'd0, bus.pulsador}, 32'd1);

    $display("service: blanco high 10 cycles");
    bus.blanco = 1'b1;
    tick();
    check("walk_puls", {31'd0, bus.pulsador}, 32'd0);
    check("walk_esp", {31'd0, bus.espera}, 32'd0);
    check("walk_serv", {24'd0, bus.servicios}, 32'd1);
    repeat (9) tick();
    bus.blanco = 1'b0;
    repeat (5) tick();
`ifdef BOTON_PEATON_LOCKOUT_EN
    $display("lockout: press 5 cycles after walk ends");
    bus.boton_raw = 1'b1;
    repeat (8) tick();
    check("lock_ignored", {31'd0, bus.pulsador}, 32'd0);
    bus.boton_raw = 1'b0;
    repeat (7) tick();
    press_check("after_lock");
`else
    $display("no lockout: press 5 cycles after walk ends");
    press_check("no_lock");
`endif
    serve("second", 2);

    $display("press consumed by walk in IDLE");
    bus.boton_raw = 1'b1;
    repeat (DEB + 2) tick();
    bus.blanco = 1'b1;
    tick();
    check("consume_puls", {31'd0, bus.pulsador}, 32'd0);
    repeat (2) tick();
    bus.blanco    = 1'b0;
    bus.boton_raw = 1'b0;
    tick();
    check("consume_serv", {24'd0, bus.servicios}, 32'd2);
`ifdef BOTON_PEATON_LOCKOUT_EN
    repeat (LOCK + 1) tick();
`endif
    repeat (10) tick();
    check("consume_idle", {31'd0, bus.pulsador}, 32'd0);

    $display("saturation: 260 press/serve rounds");
    rst = 1'b1;
    #2;
    check("sat_rst_serv", {24'd0, bus.servicios}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 260; i++) begin
      press_check("sat");
      serve("sat", (i + 1 > 255) ? 255 : i + 1);
    end
    check("sat_final", {24'd0, bus.servicios}, 32'd255);

    $display("conflict: blanco with verde for 1 cycle");
    check("conf_clean", {31'd0, bus.conflicto}, 32'd0);
    bus.rojo   = 1'b0;
    bus.verde  = 1'b1;
    bus.blanco = 1'b1;
    tick();
    bus.rojo   = 1'b1;
    bus.verde  = 1'b0;
    bus.blanco = 1'b0;
    check("conf_set", {31'd0, bus.conflicto}, 32'd1);
    repeat (100) tick();
    check("conf_sticky", {31'd0, bus.conflicto}, 32'd1);
    rst = 1'b1;
    #2;
    check("conf_rst", {31'd0, bus.conflicto}, 32'd0);
    rst = 1'b0;
    repeat (LOCK + 3) tick();
    bus.rojo = 1'b0;
    tick();
    bus.rojo = 1'b1;
    check("conf_dark", {31'd0, bus.conflicto}, 32'd1);
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) tick();

    $display("reset mid-request");
    press_check("mid");
    rst = 1'b1;
    #2;
    check("mid_puls", {31'd0, bus.pulsador}, 32'd0);
    check("mid_esp", {31'd0, bus.espera}, 32'd0);
    #8 rst = 1'b0;
    repeat (20) tick();
    check("mid_after_puls", {31'd0, bus.pulsador}, 32'd0);
    check("mid_after_esp", {31'd0, bus.espera}, 32'd0);

    $display("button held across reset release");
    bus.boton_raw = 1'b1;
    tick();
    rst = 1'b1;
    #2;
    check("held_rst_puls", {31'd0, bus.pulsador}, 32'd0);
    #8 rst = 1'b0;
    repeat (DEB + 2) tick();
    check("held_pre", {31'd0, bus.pulsador}, 32'd0);
    tick();
    check("held_puls", {31'd0, bus.pulsador}, 32'd1);
    bus.boton_raw = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/boton_peaton.md
BOTON_PEATON -- requirements
Module: boton_peaton

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4, consecutive synchronized cycles needed to accept a level change on boton_raw (range 2..255).
REQ-002 SHALL have parameter LOCK_CYCLES, default 16, lockout length in cycles after a walk phase ends (range 1..65535; used only with the macro).
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port boton_raw, input, 1, raw pedestrian push-button, asynchronous and bouncing.
REQ-006 SHALL have ports rojo, amarillo, verde and blanco, each input, 1, lamp outputs of the semaforo controller; blanco means pedestrian walk.
REQ-007 SHALL have port pulsador, output, 1, registered walk request to the semaforo controller.
REQ-008 SHALL have port espera, output, 1, registered "request pending" pedestrian indicator.
REQ-009 SHALL have port servicios, output, 8, registered count of served requests.
REQ-010 SHALL have port conflicto, output, 1, registered sticky lamp-conflict error flag.

Function
REQ-011 SHALL pass boton_raw through a 2-flop synchronizer before any other use.
REQ-012 SHALL update the debounced level only after the synchronized value differs from it for DEB_CYCLES consecutive cycles; the counter SHALL clear on any cycle where they match.
REQ-013 SHALL generate a 1-cycle press event on each debounced 0->1 transition; a debounced 1->0 transition SHALL generate no event.
REQ-014 SHALL implement FSM states IDLE, PEND, WALK and LOCK; pulsador and espera SHALL be 1 only in PEND and 0 in all other states.
REQ-015 SHALL go IDLE->PEND on a press event while blanco=0.
REQ-016 SHALL go IDLE->WALK when blanco=1; a press event in the same cycle SHALL be consumed and SHALL NOT increment servicios.
REQ-017 SHALL go PEND->WALK on the first cycle blanco=1 and increment servicios by 1 in that transition, saturating at 255.
REQ-018 SHALL ignore press events in PEND, WALK and LOCK.
REQ-019 SHALL leave WALK on the first cycle blanco=0, going to LOCK when the macro is defined and to IDLE otherwise.
REQ-020 SHALL stay in LOCK for exactly LOCK_CYCLES cycles and then go to IDLE; blanco=1 during LOCK SHALL NOT change state.
REQ-021 SHALL make pulsador rise on the (DEB_CYCLES+3)-th rising clk edge after a clean boton_raw 0->1 that lands between edges, when starting from IDLE with blanco=0.
REQ-022 SHALL set conflicto on any cycle where blanco=1 together with verde=1 or amarillo=1, or where rojo, amarillo and verde are all 0; conflicto SHALL then stay 1 until reset, and the FSM SHALL be unaffected by it.

Reset
REQ-023 SHALL, while rst=1, asynchronously force state IDLE, pulsador=0, espera=0, servicios=0, conflicto=0, and clear the synchronizer flops, debounced level, debounce counter and lock counter to 0.
REQ-024 SHALL, on rst asserted mid-PEND or mid-LOCK, drop the pending request or lockout with no later effect after release.
REQ-025 SHALL, when boton_raw is held high across reset release, accept it as a new press after the normal debounce delay.

Configuration
REQ-026 SHALL, with BOTON_PEATON_LOCKOUT_EN defined, include the LOCK state and its 16-bit counter, so presses are ignored for LOCK_CYCLES cycles after each walk phase.
REQ-027 SHALL, without BOTON_PEATON_LOCKOUT_EN, omit the LOCK state and its counter, make WALK exit directly to IDLE, and ignore LOCK_CYCLES.

Verification
REQ-028 SHALL test a clean press: DEB_CYCLES=4, boton_raw 0->1 held 20 cycles, blanco=0 -> pulsador=1 and espera=1 from edge 7, both held.
REQ-029 SHALL test bounce: boton_raw toggles every 2 cycles for 20 cycles then rests at 0 -> pulsador stays 0 and servicios stays 0.
REQ-030 SHALL test service: PEND, then blanco=1 for 10 cycles, then blanco=0 -> pulsador=0 the cycle after blanco rises, servicios=1; with the macro, a press 5 cycles after blanco falls is ignored, and a press issued 20 cycles after blanco falls gives pulsador=1.
REQ-031 SHALL test saturation: 260 press/serve cycles -> servicios=255.
REQ-032 SHALL test conflict: blanco=1 with verde=1 for 1 cycle -> conflicto=1 on the next edge and still 1 100 cycles later; rst pulse -> conflicto=0.
REQ-033 SHALL test reset mid-request: rst pulsed 10 ns in PEND -> pulsador=0 and espera=0 immediately, state IDLE, no request after release while boton_raw=0.
